// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and its neighbours: program counter control,
// instruction memory read port, decode handshake, branch redirect input and fetch counter.
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
);
   logic [ADDR_W-1:0]  pc_out;
   logic [1:0]         ps;
   logic [ADDR_W-1:0]  pc_in;
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rvalid;
   logic [INSTR_W-1:0] mem_rdata;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               br_valid;
   logic [1:0]         br_mode;
   logic [ADDR_W-1:0]  br_target;
   logic [CNT_W-1:0]   fetch_count;

   // Sequencer side.
   modport master (
      input  pc_out, mem_rvalid, mem_rdata, instr_ready, br_valid, br_mode, br_target,
      output ps, pc_in, mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count
   );

   // Environment side: program counter, instruction memory, decode, branch unit.
   modport slave (
      output pc_out, mem_rvalid, mem_rdata, instr_ready, br_valid, br_mode, br_target,
      input  ps, pc_in, mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: steers the program counter through ps/pc_in,
// reads instruction memory, and hands instructions to decode; branches preempt everything else.
module fetch_sequencer #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   fetch_sequencer_if.master   fs_if,
   output logic [2:0]          state_o
);
   // Decode handshake: an instruction transfers on a rising edge where instr_valid=1 and
   // instr_ready=1 and no branch is accepted; instr/instr_pc/instr_valid stay stable until then.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_ADV   = 3'd4,
      S_REDIR = 3'd5,
      S_DRAIN = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic               drop_q, drop_d;
   logic [1:0]         ps_q, ps_d;
   logic [ADDR_W-1:0]  pc_in_q, pc_in_d;
   logic               mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               br_take;

   assign br_take = fs_if.br_valid && fs_if.br_mode[1] &&
                    (state_q != S_REDIR) && (state_q != S_DRAIN);

   always_comb begin
      state_d       = state_q;
      drop_d        = drop_q;
      ps_d          = 2'b00;
      pc_in_d       = pc_in_q;
      mem_req_d     = 1'b0;
      mem_addr_d    = mem_addr_q;
      instr_valid_d = instr_valid_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      count_d       = count_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            mem_req_d  = 1'b1;
            mem_addr_d = fs_if.pc_out;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (fs_if.mem_rvalid) begin
               if (!drop_q) begin
                  instr_d       = fs_if.mem_rdata;
                  instr_pc_d    = mem_addr_q;
                  instr_valid_d = 1'b1;
                  state_d       = S_HOLD;
               end else begin
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (fs_if.instr_ready) begin
               instr_valid_d = 1'b0;
               count_d       = count_q + CNT_W'(1);
               ps_d          = 2'b01;
               state_d       = S_ADV;
            end
         end
         S_ADV: state_d = S_REQ;
         S_REDIR: begin
            // The dropped response may already land during the redirect cycle.
            if (!drop_q) begin
               state_d = S_REQ;
            end else if (fs_if.mem_rvalid) begin
               drop_d  = 1'b0;
               state_d = S_REQ;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fs_if.mem_rvalid) begin
               drop_d  = 1'b0;
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (br_take) begin
         state_d       = S_REDIR;
         ps_d          = fs_if.br_mode;
         pc_in_d       = fs_if.br_target;
         instr_valid_d = 1'b0;
         count_d       = count_q;
         if (state_q == S_REQ) begin
            drop_d = 1'b1;
         end else if (state_q == S_WAIT) begin
            drop_d = !fs_if.mem_rvalid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         drop_q        <= 1'b0;
         ps_q          <= 2'b00;
         pc_in_q       <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         drop_q        <= drop_d;
         ps_q          <= ps_d;
         pc_in_q       <= pc_in_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
         instr_valid_q <= instr_valid_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         count_q       <= count_d;
      end
   end

   assign fs_if.ps          = ps_q;
   assign fs_if.pc_in       = pc_in_q;
   assign fs_if.mem_req     = mem_req_q;
   assign fs_if.mem_addr    = mem_addr_q;
   assign fs_if.instr_valid = instr_valid_q;
   assign fs_if.instr       = instr_q;
   assign fs_if.instr_pc    = instr_pc_q;
   assign fs_if.fetch_count = count_q;
   assign state_o           = state_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a program-counter model, a latency-programmable
// instruction memory and a decode-side scoreboard of expected {pc, instr} pairs.
module tb_fetch_sequencer;
   logic       clk;
   logic       rst;
   logic [2:0] state;

   fetch_sequencer_if #(.ADDR_W(64), .INSTR_W(32), .CNT_W(32)) fsb ();

   fetch_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .fs_if   (fsb),
      .state_o (state)
   );

   int          n_pass = 0;
   int          n_chk  = 0;
   logic [95:0] exp_q[$];
   int          exp_count = 0;

   int          mem_lat    = 1;
   bit          rv_toggle  = 0;
   bit          rsp_pending = 0;
   int          rsp_cnt    = 0;
   logic [31:0] rsp_data   = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'hAAAA_0000 + 32'(a >> 2) + 32'd1;
   endfunction

   // Program counter: ps 01 adds 4, 10 loads pc_in, 11 adds pc_in.
   logic [63:0] pc_q;
   always @(posedge clk) begin
      if (!rst) pc_q <= '0;
      else begin
         case (fsb.ps)
            2'b01:   pc_q <= pc_q + 64'd4;
            2'b10:   pc_q <= fsb.pc_in;
            2'b11:   pc_q <= pc_q + fsb.pc_in;
            default: pc_q <= pc_q;
         endcase
      end
   end
   assign fsb.pc_out = pc_q;

   // Instruction memory: answers mem_req after mem_lat cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (rv_toggle) begin
            fsb.mem_rvalid = ~fsb.mem_rvalid;
         end else begin
            fsb.mem_rvalid = 1'b0;
            if (rsp_pending) begin
               if (rsp_cnt <= 1) begin
                  fsb.mem_rvalid = 1'b1;
                  fsb.mem_rdata  = rsp_data;
                  rsp_pending    = 0;
               end else begin
                  rsp_cnt--;
               end
            end
            if (fsb.mem_req) begin
               chk("one_outstanding", 64'(rsp_pending), 64'd0);
               rsp_pending = 1;
               rsp_cnt     = mem_lat;
               rsp_data    = mem_word(fsb.mem_addr);
            end
         end
      end
   end

   // Decode-side monitor: every transfer is popped and compared, then the advance pulse is checked.
   initial begin
      logic [95:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rst && fsb.instr_valid && fsb.instr_ready && !(fsb.br_valid && fsb.br_mode[1])) begin
            n_chk++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL sb_unexpected: observed instr %0h at %0h, expected none", fsb.instr, fsb.instr_pc);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("instr", 64'(fsb.instr), 64'(e[31:0]));
               chk("instr_pc", fsb.instr_pc, e[95:32]);
            end
            exp_count++;
            @(negedge clk);
            #2;
            chk("ps_adv", 64'(fsb.ps), 64'd1);
            chk("fetch_count", 64'(fsb.fetch_count), 64'(exp_count));
            @(negedge clk);
            #2;
            chk("ps_after_adv", 64'(fsb.ps), 64'd0);
         end
      end
   end

   task automatic wait_q_empty(input int max);
      int k = 0;
      while (exp_q.size() != 0 && k < max) begin
         tick();
         k++;
      end
      chk("sb_drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid(input int max);
      int k = 0;
      while (!fsb.instr_valid && k < max) begin
         tick();
         k++;
      end
      chk("valid_seen", 64'(fsb.instr_valid), 64'd1);
   endtask

   task automatic wait_req(input int max);
      int k = 0;
      while (!fsb.mem_req && k < max) begin
         tick();
         k++;
      end
      chk("req_seen", 64'(fsb.mem_req), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit seen_rv;
      int k;
      rst             = 1'b0;
      fsb.instr_ready = 1'b0;
      fsb.br_valid    = 1'b0;
      fsb.br_mode     = 2'b00;
      fsb.br_target   = '0;
      fsb.mem_rvalid  = 1'b0;
      fsb.mem_rdata   = '0;

      // Reset hold with mem_rvalid toggling.
      rv_toggle = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mem_req", 64'(fsb.mem_req), 64'd0);
      end
      rv_toggle = 0;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_ps", 64'(fsb.ps), 64'd0);
      chk("rst_pc_in", fsb.pc_in, 64'd0);
      chk("rst_mem_addr", fsb.mem_addr, 64'd0);
      chk("rst_instr_valid", 64'(fsb.instr_valid), 64'd0);
      chk("rst_instr", 64'(fsb.instr), 64'd0);
      chk("rst_instr_pc", fsb.instr_pc, 64'd0);
      chk("rst_fetch_count", 64'(fsb.fetch_count), 64'd0);

      // Sequential fetch, latency 1, decode always ready.
      tick();
      rst = 1'b1;
      fsb.instr_ready = 1'b1;
      exp_q.push_back({64'd0, 32'hAAAA_0001});
      exp_q.push_back({64'd4, 32'hAAAA_0002});
      tick();
      chk("first_req_not_yet", 64'(fsb.mem_req), 64'd0);
      tick();
      chk("first_req", 64'(fsb.mem_req), 64'd1);
      chk("first_addr", fsb.mem_addr, 64'd0);
      wait_q_empty(60);
      fsb.instr_ready = 1'b0;
      tick();
      chk("seq_count", 64'(fsb.fetch_count), 64'd2);

      // Backpressure in HOLD.
      exp_q.push_back({64'd8, 32'hAAAA_0003});
      wait_valid(20);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 64'(fsb.instr_valid), 64'd1);
         chk("bp_instr", 64'(fsb.instr), 64'hAAAA_0003);
         chk("bp_ps", 64'(fsb.ps), 64'd0);
         tick();
      end
      fsb.instr_ready = 1'b1;
      wait_q_empty(20);
      fsb.instr_ready = 1'b0;

      // Absolute branch in HOLD colliding with a ready handshake.
      wait_valid(20);
      chk("hold_pc", fsb.instr_pc, 64'd12);
      fsb.instr_ready = 1'b1;
      fsb.br_valid    = 1'b1;
      fsb.br_mode     = 2'b10;
      fsb.br_target   = 64'd16;
      tick();
      fsb.br_valid    = 1'b0;
      fsb.instr_ready = 1'b0;
      chk("abs_ps", 64'(fsb.ps), 64'd2);
      chk("abs_pc_in", fsb.pc_in, 64'd16);
      chk("abs_valid", 64'(fsb.instr_valid), 64'd0);
      chk("abs_count", 64'(fsb.fetch_count), 64'd3);
      exp_q.push_back({64'd16, 32'hAAAA_0005});
      tick();
      chk("abs_ps_one_cycle", 64'(fsb.ps), 64'd0);
      tick();
      chk("abs_req", 64'(fsb.mem_req), 64'd1);
      chk("abs_addr", fsb.mem_addr, 64'd16);
      fsb.instr_ready = 1'b1;
      wait_q_empty(30);
      fsb.instr_ready = 1'b0;
      mem_lat = 3;

      // Relative branch while a latency-3 read is in flight.
      wait_req(20);
      chk("inflight_addr", fsb.mem_addr, 64'd20);
      fsb.br_valid  = 1'b1;
      fsb.br_mode   = 2'b11;
      fsb.br_target = 64'd32;
      tick();
      fsb.br_valid = 1'b0;
      chk("rel_ps", 64'(fsb.ps), 64'd3);
      chk("rel_pc_in", fsb.pc_in, 64'd32);
      exp_q.push_back({64'd52, 32'hAAAA_000E});
      seen_rv = 0;
      k = 0;
      while (!fsb.mem_req && k < 30) begin
         if (fsb.mem_rvalid) seen_rv = 1;
         tick();
         k++;
      end
      chk("rel_req_seen", 64'(fsb.mem_req), 64'd1);
      chk("req_after_stale", 64'(seen_rv), 64'd1);
      chk("rel_addr", fsb.mem_addr, 64'd52);
      fsb.instr_ready = 1'b1;
      wait_q_empty(40);
      fsb.instr_ready = 1'b0;
      mem_lat = 1;

      // Non-redirecting branch mode is ignored.
      wait_req(20);
      fsb.br_valid  = 1'b1;
      fsb.br_mode   = 2'b01;
      fsb.br_target = 64'd100;
      tick();
      fsb.br_valid = 1'b0;
      chk("ign_ps", 64'(fsb.ps), 64'd0);
      exp_q.push_back({64'd56, 32'hAAAA_000F});
      fsb.instr_ready = 1'b1;
      wait_q_empty(30);
      fsb.instr_ready = 1'b0;
      mem_lat = 2;

      // Reset while waiting on memory; the late response must be ignored.
      wait_req(20);
      chk("mid_addr", fsb.mem_addr, 64'd60);
      rst = 1'b0;
      exp_count = 0;
      tick();
      rst = 1'b1;
      chk("mid_state", 64'(state), 64'd0);
      chk("mid_valid", 64'(fsb.instr_valid), 64'd0);
      chk("mid_count", 64'(fsb.fetch_count), 64'd0);
      chk("mid_req", 64'(fsb.mem_req), 64'd0);
      tick();
      tick();
      chk("late_rv_ignored", 64'(fsb.instr_valid), 64'd0);
      chk("post_rst_req", 64'(fsb.mem_req), 64'd1);
      chk("post_rst_addr", fsb.mem_addr, 64'd0);
      exp_q.push_back({64'd0, 32'hAAAA_0001});
      fsb.instr_ready = 1'b1;
      wait_q_empty(30);
      fsb.instr_ready = 1'b0;
      tick();
      tick();
      chk("final_count", 64'(fsb.fetch_count), 64'd1);
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
